// File: rtl/life_pkg.sv
// Grid geometry and palette shared by the renderer, the life engine and the cell RAM.
package life_pkg;

    localparam int CELL_SHIFT = 3;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int ADDR_W     = 13;
    localparam bit SHOW_GRID  = 1'b1;

    localparam logic [2:0] ALIVE_RGB  = 3'b010;
    localparam logic [2:0] DEAD_RGB   = 3'b000;
    localparam logic [2:0] GRID_RGB   = 3'b001;
    localparam logic [2:0] BORDER_RGB = 3'b100;

endpackage

// File: rtl/life_bank_swap.sv
// Owns the displayed-bank pointer: flips it on a vsync falling edge once the
// engine reports a finished generation, and acknowledges with a one-cycle pulse.
module life_bank_swap
    import life_pkg::*;
(
    input  logic clk_36MHz,
    input  logic rst_n,
    input  logic vsync,
    input  logic gen_ready,
    output logic gen_ack,
    output logic display_bank
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_DROP
    } swap_state_t;

    swap_state_t state_q;
    logic        vsync_q;
    logic        gen_ack_q;
    logic        display_bank_q;
    logic        frame_edge;

    assign frame_edge = vsync_q & ~vsync;

    // A gen_ready that drops while ARMED is ignored; the swap still happens.
    always_ff @(posedge clk_36MHz) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vsync_q        <= 1'b1;
            gen_ack_q      <= 1'b0;
            display_bank_q <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            gen_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gen_ready) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (frame_edge) begin
                        display_bank_q <= ~display_bank_q;
                        gen_ack_q      <= 1'b1;
                        state_q        <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (!gen_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gen_ack      = gen_ack_q;
    assign display_bank = display_bank_q;

endmodule

// File: rtl/life_pixel_renderer.sv
// Maps VGA pixel coordinates onto the life grid and colours each pixel from the
// displayed cell bank through a fixed three-stage pipeline.
module life_pixel_renderer #(
    parameter int CELL_SHIFT = life_pkg::CELL_SHIFT,
    parameter int GRID_W     = life_pkg::GRID_W,
    parameter int GRID_H     = life_pkg::GRID_H,
    parameter int ADDR_W     = life_pkg::ADDR_W,
    parameter bit SHOW_GRID  = life_pkg::SHOW_GRID
) (
    input  logic              clk_36MHz,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              vsync,
    input  logic              gen_ready,
    output logic              gen_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_bank,
    input  logic              ram_rdata,
    output logic              display_bank,
    output logic [2:0]        rgb
);

    import life_pkg::ALIVE_RGB;
    import life_pkg::DEAD_RGB;
    import life_pkg::GRID_RGB;
    import life_pkg::BORDER_RGB;

    localparam logic [9:0]  GRID_W_C = 10'(GRID_W);
    localparam logic [9:0]  GRID_H_C = 10'(GRID_H);
    localparam logic [19:0] STRIDE_C = 20'(GRID_W);
    localparam logic [9:0]  SUB_MASK = 10'((1 << CELL_SHIFT) - 1);

    logic [9:0]        col;
    logic [9:0]        row;
    logic [19:0]       addr_full;
    logic              in_grid_d;
    logic              on_line_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [2:0]        rgb_d;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_bank_q;
    logic              in_grid_q1, on_line_q1;
    logic              in_grid_q2, on_line_q2;
    logic [2:0]        rgb_q;

    life_bank_swap u_bank_swap (
        .clk_36MHz    (clk_36MHz),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .gen_ready    (gen_ready),
        .gen_ack      (gen_ack),
        .display_bank (display_bank)
    );

    always_comb begin
        col        = x >> CELL_SHIFT;
        row        = y >> CELL_SHIFT;
        in_grid_d  = (col < GRID_W_C) && (row < GRID_H_C);
        on_line_d  = SHOW_GRID && (((x & SUB_MASK) == 10'd0) || ((y & SUB_MASK) == 10'd0));
        addr_full  = {10'd0, row} * STRIDE_C + {10'd0, col};
        ram_addr_d = in_grid_d ? addr_full[ADDR_W-1:0] : '0;
    end

    // Colour is resolved against flags delayed to line up with ram_rdata.
    always_comb begin
        rgb_d = DEAD_RGB;
        if (!in_grid_q2) begin
            rgb_d = BORDER_RGB;
        end else if (ram_rdata) begin
            rgb_d = ALIVE_RGB;
        end else if (on_line_q2) begin
            rgb_d = GRID_RGB;
        end
    end

    always_ff @(posedge clk_36MHz) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            ram_bank_q <= 1'b0;
            in_grid_q1 <= 1'b0;
            on_line_q1 <= 1'b0;
            in_grid_q2 <= 1'b0;
            on_line_q2 <= 1'b0;
            rgb_q      <= 3'b000;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_bank_q <= display_bank;
            in_grid_q1 <= in_grid_d;
            on_line_q1 <= on_line_d;
            in_grid_q2 <= in_grid_q1;
            on_line_q2 <= on_line_q1;
            rgb_q      <= rgb_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_bank = ram_bank_q;
    assign rgb      = rgb_q;

endmodule

// File: doc/life_pixel_renderer.md
Name: life_pixel_renderer

Overview:
Upstream pixel source for vga_controller. Maps the controller's active-video pixel coordinates (x, y) onto the Game of Life cell grid and reads the cell state from a double-banked cell RAM. Drives the controller's 3-bit rgb input.
Also owns the displayed-bank pointer. It swaps banks only at a frame boundary (vsync falling edge) after the life engine signals that a new generation is complete.

Parameters:
CELL_SHIFT, 3, log2 of cell size in pixels (8x8 px cells)
GRID_W, 80, grid width in cells
GRID_H, 60, grid height in cells
ADDR_W, 13, cell RAM address width per bank (must satisfy 2^ADDR_W >= GRID_W*GRID_H)
ALIVE_RGB, 3'b010, colour of a live cell
DEAD_RGB, 3'b000, colour of a dead cell
GRID_RGB, 3'b001, grid-line colour
BORDER_RGB, 3'b100, colour of pixels outside the grid
SHOW_GRID, 1, 1 = draw grid lines on dead cells

Ports:
clk_36MHz  in  1  pixel clock, shared with vga_controller
rst_n  in  1  synchronous active-low reset
x  in  10  active pixel column from vga_controller
y  in  10  active pixel row from vga_controller
vsync  in  1  active-low vsync from vga_controller
gen_ready  in  1  life engine: new generation written to back bank; level, held until gen_ack
gen_ack  out  1  one-cycle pulse: swap done, engine may start writing the new back bank
ram_addr  out  ADDR_W  cell RAM read address (row*GRID_W + col)
ram_bank  out  1  cell RAM bank select for the read (= display_bank)
ram_rdata  in  1  cell state, valid one cycle after ram_addr (synchronous RAM)
display_bank  out  1  bank currently displayed; the engine writes ~display_bank
rgb  out  3  colour {r,g,b} to vga_controller

Behaviour:
- Reset (rst_n=0 at a clk_36MHz edge): rgb=0, ram_addr=0, ram_bank=0, display_bank=0, gen_ack=0, swap FSM=IDLE, vsync_q=1, all pipeline flags cleared. Reset mid-frame or mid-handshake discards the pending swap.
- Cell mapping: col = x >> CELL_SHIFT, row = y >> CELL_SHIFT.
  - in_grid = (col < GRID_W) && (row < GRID_H).
  - on_line = SHOW_GRID && (x[CELL_SHIFT-1:0]==0 || y[CELL_SHIFT-1:0]==0).
- Address: row*GRID_W + col, computed at full width and truncated to ADDR_W. When !in_grid, ram_addr=0.
- Pipeline, fixed latency 3 cycles from x,y to rgb:
  - Edge 1: register ram_addr, ram_bank, in_grid, on_line.
  - Edge 2: RAM returns ram_rdata; flags are delayed one stage.
  - Edge 3: register rgb.
  - No stalls; a new x,y is accepted every cycle.
- Colour priority at edge 3:
  - !in_grid → BORDER_RGB
  - else ram_rdata=1 → ALIVE_RGB
  - else on_line → GRID_RGB
  - else DEAD_RGB
- Blanking: vga_controller forces x=y=0 there, so the renderer reads cell (0,0); vga_controller masks the output. No special handling required.
- vsync_q registers vsync each cycle. frame_edge = vsync_q & ~vsync (falling edge).
- Swap FSM:
  - IDLE: gen_ready=1 → ARMED.
  - ARMED: frame_edge → toggle display_bank, gen_ack=1 for exactly one cycle, → WAIT_DROP.
  - WAIT_DROP: gen_ready=0 → IDLE. While in WAIT_DROP, no further swap occurs even on frame_edge.
- Simultaneous events:
  - gen_ready rising on the same cycle as frame_edge (FSM in IDLE): no swap this frame; the swap occurs at the next frame_edge.
  - gen_ready dropping while ARMED (protocol violation): stay ARMED. The swap still occurs at the next frame_edge.
- display_bank changes only on the cycle after a frame_edge, which falls inside vertical blanking. No active pixel is ever read from a mixed bank.

Decomposition:
- Shared package life_pkg: GRID_W, GRID_H, CELL_SHIFT, ADDR_W and the colour constants. The life engine and the cell RAM use the same values.
- The swap FSM enum (IDLE/ARMED/WAIT_DROP) is local.
- One natural sub-module: life_bank_swap, containing vsync edge detection, the swap FSM, display_bank and gen_ack. The top holds the address/colour pipeline.

Test Plan:
- Reset check: hold rst_n=0 for 4 cycles with random inputs → rgb=0, gen_ack=0, display_bank=0, ram_addr=0. The first rgb after release is valid 3 cycles after the first x,y.
- Address/latency: x=17, y=9 (col 2, row 1) → ram_addr=82 after 1 cycle. With the RAM model cell 82=1, rgb=3'b010 exactly 3 cycles after x,y is applied.
- Grid/dead: x=16, y=12, cell dead → rgb=GRID_RGB 3'b001. x=17, y=9 with cell dead → rgb=3'b000. Rerun with SHOW_GRID=0 at x=16 → rgb=3'b000.
- Border: GRID_W=64 build, x=520, y=100 → ram_addr=0, rgb=BORDER_RGB 3'b100.
- Swap handshake:
  - Raise gen_ready mid-frame → no change until the vsync fall; then display_bank 0→1 and a single-cycle gen_ack.
  - Hold gen_ready through two more vsync falls → no further toggle.
  - Drop gen_ready, raise it again → the next vsync fall toggles display_bank 1→0.
- Simultaneous/reset: gen_ready rises on the exact cycle of the vsync fall → no swap that frame, swap at the next one. Assert rst_n=0 while ARMED → display_bank=0, no gen_ack.
